// File: rtl/rc522_pkg.sv
// rc522_pkg: MFRC-522 register map, init-table type/contents, sequencer state and owner encodings.
package rc522_pkg;
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } init_entry_t;

    localparam int MAX_INIT = 15;
    typedef init_entry_t [0:MAX_INIT-1] init_table_t;

    localparam logic [7:0] COMMAND_REG     = 8'h01;
    localparam logic [7:0] T_MODE_REG      = 8'h2A;
    localparam logic [7:0] T_PRESCALER_REG = 8'h2B;
    localparam logic [7:0] T_RELOAD_REG_L  = 8'h2D;
    localparam logic [7:0] T_RELOAD_REG_H  = 8'h2C;
    localparam logic [7:0] TX_ASK_REG      = 8'h15;
    localparam logic [7:0] MODE_REG        = 8'h11;
    localparam logic [7:0] COM_IRQ_REG     = 8'h04;

    localparam init_table_t DEFAULT_TABLE = '{
        '{COMMAND_REG,     8'h0F},
        '{T_MODE_REG,      8'h8D},
        '{T_PRESCALER_REG, 8'h3E},
        '{T_RELOAD_REG_L,  8'h1E},
        '{T_RELOAD_REG_H,  8'h00},
        '{TX_ASK_REG,      8'h40},
        '{MODE_REG,        8'h3D},
        '0, '0, '0, '0, '0, '0, '0, '0
    };

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_INIT_ISSUE = 4'd1;
    localparam logic [3:0] S_INIT_WAIT  = 4'd2;
    localparam logic [3:0] S_SETTLE     = 4'd3;
    localparam logic [3:0] S_POLL_GAP   = 4'd4;
    localparam logic [3:0] S_POLL_ISSUE = 4'd5;
    localparam logic [3:0] S_POLL_WAIT  = 4'd6;
    localparam logic [3:0] S_REPORT     = 4'd7;
    localparam logic [3:0] S_ERR        = 4'd8;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_READ  = 2'd1;
    localparam logic [1:0] OWN_WRITE = 2'd2;
endpackage

// File: rtl/rc522_spi_mux.sv
// rc522_spi_mux: routes the SPI pins from whichever engine currently owns the bus; idle bus is SCK=0, SDA=1, MOSI=0.
module rc522_spi_mux
    import rc522_pkg::*;
(
    input  logic [1:0] i_owner,
    input  logic       i_rd_sck,
    input  logic       i_rd_sda,
    input  logic       i_rd_mosi,
    input  logic       i_wr_sck,
    input  logic       i_wr_sda,
    input  logic       i_wr_mosi,
    output logic       o_sck,
    output logic       o_sda,
    output logic       o_mosi
);
    always_comb begin
        o_sck  = (i_owner == OWN_READ) ? i_rd_sck  : (i_owner == OWN_WRITE) ? i_wr_sck  : 1'b0;
        o_sda  = (i_owner == OWN_READ) ? i_rd_sda  : (i_owner == OWN_WRITE) ? i_wr_sda  : 1'b1;
        o_mosi = (i_owner == OWN_READ) ? i_rd_mosi : (i_owner == OWN_WRITE) ? i_wr_mosi : 1'b0;
    end
endmodule

// File: rtl/rc522_reg_sequencer.sv
// rc522_reg_sequencer: replays the MFRC-522 init table through the write engine, then polls one
// status register through the read engine and reports non-zero masked results.
module rc522_reg_sequencer
    import rc522_pkg::*;
#(
    parameter int          INIT_LEN     = 7,
    parameter logic [7:0]  POLL_ADDR    = COM_IRQ_REG,
    parameter logic [7:0]  POLL_MASK    = 8'h30,
    parameter logic [15:0] POLL_GAP     = 16'd50000,
    parameter logic [11:0] DONE_TIMEOUT = 12'd1024,
    parameter init_table_t INIT_TABLE   = DEFAULT_TABLE
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_card_valid,
    output logic [7:0] o_card_data,
    output logic       o_error,
    output logic       o_rd_start,
    output logic [7:0] o_rd_addr,
    input  logic       i_rd_done,
    input  logic [7:0] i_rd_data,
    output logic       o_wr_start,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    input  logic       i_wr_done,
    input  logic       i_rd_sck,
    input  logic       i_rd_sda,
    input  logic       i_rd_mosi,
    input  logic       i_wr_sck,
    input  logic       i_wr_sda,
    input  logic       i_wr_mosi,
    output logic       o_sck,
    output logic       o_sda,
    output logic       o_mosi
);
    localparam logic [3:0] LAST_IDX = 4'(INIT_LEN - 1);

    logic [3:0]  r_state;
    logic [3:0]  r_idx;
    logic [15:0] r_gap;
    logic [11:0] r_tmo;
    logic [1:0]  r_owner;
    logic [7:0]  r_poll;
    logic        r_init_done, r_card_valid, r_error, r_rd_start, r_wr_start;
    logic [7:0]  r_card_data, r_rd_addr, r_wr_addr, r_wr_data;
    init_entry_t w_entry;
    logic        w_done;

    // Only the current owner's done is honoured, so a stray done from the idle engine is ignored.
    assign w_entry = INIT_TABLE[r_idx];
    assign w_done  = (r_owner == OWN_READ) ? i_rd_done : (r_owner == OWN_WRITE) ? i_wr_done : 1'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_gap        <= '0;
            r_tmo        <= '0;
            r_owner      <= OWN_NONE;
            r_poll       <= '0;
            r_init_done  <= 1'b0;
            r_card_valid <= 1'b0;
            r_error      <= 1'b0;
            r_rd_start   <= 1'b0;
            r_wr_start   <= 1'b0;
            r_card_data  <= '0;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_rd_start   <= 1'b0;
            r_wr_start   <= 1'b0;
            r_card_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_init_done <= 1'b0;
                    r_idx       <= '0;
                    if (i_enable) r_state <= S_INIT_ISSUE;
                end
                S_INIT_ISSUE: begin
                    if (!i_enable) r_state <= S_IDLE;
                    else begin
                        r_wr_start <= 1'b1;
                        r_wr_addr  <= w_entry.addr;
                        r_wr_data  <= w_entry.data;
                        r_owner    <= OWN_WRITE;
                        r_tmo      <= '0;
                        r_state    <= S_INIT_WAIT;
                    end
                end
                S_INIT_WAIT, S_POLL_WAIT: begin
                    if (w_done) begin
                        if (r_state == S_POLL_WAIT) r_poll <= i_rd_data;
                        r_state <= (r_state == S_POLL_WAIT) ? S_REPORT : S_SETTLE;
                    end else if (r_tmo == DONE_TIMEOUT - 12'd1) begin
                        r_error <= 1'b1;
                        r_owner <= OWN_NONE;
                        r_state <= S_ERR;
                    end else r_tmo <= r_tmo + 12'd1;
                end
                S_SETTLE: begin
                    r_owner <= OWN_NONE;
                    if (!i_enable) r_state <= S_IDLE;
                    else if (r_idx == LAST_IDX) begin
                        r_init_done <= 1'b1;
                        r_gap       <= '0;
                        r_state     <= S_POLL_GAP;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= S_INIT_ISSUE;
                    end
                end
                S_POLL_GAP: begin
                    if (!i_enable) r_state <= S_IDLE;
                    else if (r_gap == POLL_GAP - 16'd1) begin
                        r_gap   <= '0;
                        r_state <= S_POLL_ISSUE;
                    end else r_gap <= r_gap + 16'd1;
                end
                S_POLL_ISSUE: begin
                    if (!i_enable) r_state <= S_IDLE;
                    else begin
                        r_rd_start <= 1'b1;
                        r_rd_addr  <= POLL_ADDR;
                        r_owner    <= OWN_READ;
                        r_tmo      <= '0;
                        r_state    <= S_POLL_WAIT;
                    end
                end
                S_REPORT: begin
                    r_owner <= OWN_NONE;
                    r_gap   <= '0;
                    if (!i_enable) r_state <= S_IDLE;
                    else begin
                        if ((r_poll & POLL_MASK) != 8'h00) begin
                            r_card_valid <= 1'b1;
                            r_card_data  <= r_poll;
                        end
                        r_state <= S_POLL_GAP;
                    end
                end
                S_ERR: begin
                    if (!i_enable) begin
                        r_error <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = r_owner != OWN_NONE;
    assign o_init_done  = r_init_done;
    assign o_card_valid = r_card_valid;
    assign o_card_data  = r_card_data;
    assign o_error      = r_error;
    assign o_rd_start   = r_rd_start;
    assign o_rd_addr    = r_rd_addr;
    assign o_wr_start   = r_wr_start;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;

    rc522_spi_mux u_mux (
        .i_owner   (r_owner),
        .i_rd_sck  (i_rd_sck),
        .i_rd_sda  (i_rd_sda),
        .i_rd_mosi (i_rd_mosi),
        .i_wr_sck  (i_wr_sck),
        .i_wr_sda  (i_wr_sda),
        .i_wr_mosi (i_wr_mosi),
        .o_sck     (o_sck),
        .o_sda     (o_sda),
        .o_mosi    (o_mosi)
    );
endmodule

// File: tb/tb_rc522_reg_sequencer.sv
// tb_rc522_reg_sequencer: directed bench with simple engine models that answer each start with done 20 cycles later.
module tb_rc522_reg_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       busy, init_done, card_valid, error, rd_start, wr_start;
    logic [7:0] card_data, rd_addr, wr_addr, wr_data;
    logic       rd_done, wr_done;
    logic [7:0] rd_data;
    logic       sck, sda, mosi;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_n = 0, rd_n = 0, cv_cnt = 0;
    int wr_cnt = 0, rd_cnt = 0;
    int wr_hold = -1;
    int k, base;
    logic [7:0]  rd_value = 8'h30;
    logic [15:0] wr_log [0:63];
    int          wr_cyc [0:63];
    int          rd_cyc [0:63];
    logic [15:0] exp_tab [0:6] = '{16'h010F, 16'h2A8D, 16'h2B3E, 16'h2D1E, 16'h2C00, 16'h1540, 16'h113D};

    rc522_reg_sequencer #(.POLL_GAP(16'd40)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .o_busy       (busy),
        .o_init_done  (init_done),
        .o_card_valid (card_valid),
        .o_card_data  (card_data),
        .o_error      (error),
        .o_rd_start   (rd_start),
        .o_rd_addr    (rd_addr),
        .i_rd_done    (rd_done),
        .i_rd_data    (rd_data),
        .o_wr_start   (wr_start),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .i_wr_done    (wr_done),
        .i_rd_sck     (1'b1),
        .i_rd_sda     (1'b0),
        .i_rd_mosi    (1'b1),
        .i_wr_sck     (1'b1),
        .i_wr_sda     (1'b0),
        .i_wr_mosi    (1'b0),
        .o_sck        (sck),
        .o_sda        (sda),
        .o_mosi       (mosi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_wr(input int n, input int lim);
        for (int i = 0; i < lim && wr_n < n; i++) tick();
        check("wr_start_arrived", int'(wr_n >= n), 1);
    endtask

    task automatic wait_rd(input int n, input int lim);
        for (int i = 0; i < lim && rd_n < n; i++) tick();
        check("rd_start_arrived", int'(rd_n >= n), 1);
    endtask

    // Write engine model: logs each start, answers with a one-cycle done 20 cycles later unless withheld.
    initial begin
        wr_done = 1'b0;
        forever begin
            @(negedge clk);
            wr_done = 1'b0;
            if (!rst_n) wr_cnt = 0;
            else begin
                if (wr_cnt > 0) begin
                    wr_cnt--;
                    if (wr_cnt == 0) wr_done = 1'b1;
                end
                if (wr_start) begin
                    if (wr_n < 64) begin
                        wr_log[wr_n] = {wr_addr, wr_data};
                        wr_cyc[wr_n] = cyc;
                    end
                    wr_cnt = (wr_n == wr_hold) ? 0 : 20;
                    wr_n++;
                end
            end
        end
    end

    initial begin
        rd_done = 1'b0;
        rd_data = 8'h00;
        forever begin
            @(negedge clk);
            rd_done = 1'b0;
            if (card_valid) cv_cnt++;
            if (!rst_n) rd_cnt = 0;
            else begin
                if (rd_cnt > 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        rd_done = 1'b1;
                        rd_data = rd_value;
                    end
                end
                if (rd_start) begin
                    if (rd_n < 64) rd_cyc[rd_n] = cyc;
                    rd_cnt = 20;
                    rd_n++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("reset_pins", int'({sck, sda, mosi}), 'b010);
        check("reset_flags", int'({busy, init_done, error, card_valid, rd_start, wr_start}), 0);
        rst_n = 1'b1;
        tick(100);
        check("idle_no_wr", wr_n, 0);
        check("idle_no_rd", rd_n, 0);
        check("idle_pins", int'({sck, sda, mosi}), 'b010);

        enable = 1'b1;
        wait_wr(1, 20);
        tick(5);
        check("wr_busy", int'(busy), 1);
        check("wr_pins", int'({sck, sda, mosi}), 'b100);
        check("wr_hold_addr", int'({wr_addr, wr_data}), 'h010F);
        wait_wr(7, 300);
        for (int i = 0; i < 7; i++) check($sformatf("init_entry%0d", i), int'(wr_log[i]), int'(exp_tab[i]));
        for (int i = 1; i < 7; i++) check($sformatf("init_gap%0d", i), wr_cyc[i] - wr_cyc[i-1], 23);
        for (int i = 0; i < 40 && !init_done; i++) tick();
        check("init_done", int'(init_done), 1);
        check("init_idle_busy", int'(busy), 0);

        wait_rd(1, 200);
        tick(5);
        check("rd_pins", int'({sck, sda, mosi}), 'b101);
        check("rd_busy", int'(busy), 1);
        check("rd_addr", int'(rd_addr), 'h04);
        for (int i = 0; i < 40 && cv_cnt < 1; i++) tick();
        check("cv_seen", cv_cnt, 1);
        check("cv_data", int'(card_data), 'h30);
        check("cv_high", int'(card_valid), 1);
        tick();
        check("cv_one_cycle", int'(card_valid), 0);
        rd_value = 8'h01;
        wait_rd(2, 200);
        check("poll_spacing", rd_cyc[1] - rd_cyc[0], 63);
        tick(30);
        check("masked_no_cv", cv_cnt, 1);
        check("still_init_done", int'(init_done), 1);
        check("poll_idle_busy", int'(busy), 0);

        rd_value = 8'h30;
        wait_rd(3, 200);
        tick(3);
        enable = 1'b0;
        tick(25);
        check("drop_no_cv", cv_cnt, 1);
        check("drop_init_done", int'(init_done), 0);
        check("drop_busy", int'(busy), 0);
        check("drop_pins", int'({sck, sda, mosi}), 'b010);
        tick(60);
        check("drop_no_rd", rd_n, 3);
        check("drop_no_wr", wr_n, 7);

        base = wr_n;
        wr_hold = base + 2;
        enable = 1'b1;
        wait_wr(base + 1, 20);
        check("restart_entry", int'(wr_log[base]), 'h010F);
        wait_wr(base + 3, 200);
        for (k = 0; k < 1100 && !error; k++) tick();
        check("timeout_cycles", k, 1024);
        check("timeout_error", int'(error), 1);
        check("timeout_pins", int'({sck, sda, mosi}), 'b010);
        check("timeout_busy", int'(busy), 0);
        tick(10);
        check("err_hold_wr", wr_n, base + 3);
        check("err_sticky", int'(error), 1);
        enable = 1'b0;
        tick(3);
        check("err_cleared", int'(error), 0);

        base = wr_n;
        enable = 1'b1;
        wait_wr(base + 1, 20);
        tick(5);
        check("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flags", int'({busy, init_done, card_valid, error, rd_start, wr_start}), 0);
        check("arst_pins", int'({sck, sda, mosi}), 'b010);
        check("arst_regs", int'({wr_addr, wr_data, rd_addr, card_data}), 0);
        tick(3);
        rst_n = 1'b1;
        wait_wr(base + 2, 100);
        check("reset_restart_entry", int'(wr_log[base + 1]), 'h010F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
